// File: rtl/alu_op_sequencer.sv
// Hardwired control sequencer for one register-to-register ALU operation:
// optional Y load, execute into Z, Z-low write-back, optional Z-high write-back.
module alu_op_sequencer #(
  parameter  int NREGS = 16,
  parameter  int OPW   = 5,
  localparam int SELW  = $clog2(NREGS)
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [OPW-1:0]   opcode,
  input  logic             unary,
  input  logic [SELW-1:0]  ra,
  input  logic [SELW-1:0]  rb,
  input  logic [SELW-1:0]  rc,
  input  logic             wr_hi,
  input  logic [SELW-1:0]  rhi,
  output logic [NREGS-1:0] Rout,
  output logic [NREGS-1:0] Rin,
  output logic             Yin,
  output logic             ZHighin,
  output logic             Zlowin,
  output logic             Zhighout,
  output logic             Zlowout,
  output logic [OPW-1:0]   op,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE
  } state_e;

  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic            unary;
    logic [SELW-1:0] ra;
    logic [SELW-1:0] rb;
    logic [SELW-1:0] rc;
    logic            wr_hi;
    logic [SELW-1:0] rhi;
  } fields_t;

  typedef struct packed {
    logic [NREGS-1:0] rout;
    logic [NREGS-1:0] rin;
    logic             yin;
    logic             zhighin;
    logic             zlowin;
    logic             zhighout;
    logic             zlowout;
    logic [OPW-1:0]   op;
    logic             busy;
    logic             done;
  } outs_t;

  state_e  state_q, state_d;
  fields_t fld_q, fld_d;
  outs_t   outs_q, outs_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    outs_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          fld_d = '{opcode: opcode, unary: unary, ra: ra, rb: rb, rc: rc,
                    wr_hi: wr_hi, rhi: rhi};
          state_d = unary ? EXEC : LOAD_Y;
        end
      end
      LOAD_Y:  state_d = EXEC;
      EXEC:    state_d = WB_LO;
      WB_LO:   state_d = fld_q.wr_hi ? WB_HI : DONE;
      WB_HI:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the state being entered, so the registered
    // outputs line up exactly with the cycle that state is active.
    unique case (state_d)
      LOAD_Y: begin
        outs_d.rout = NREGS'(1) << fld_d.rb;
        outs_d.yin  = 1'b1;
        outs_d.busy = 1'b1;
      end
      EXEC: begin
        outs_d.rout    = NREGS'(1) << fld_d.rc;
        outs_d.op      = fld_d.opcode;
        outs_d.zhighin = 1'b1;
        outs_d.zlowin  = 1'b1;
        outs_d.busy    = 1'b1;
      end
      WB_LO: begin
        outs_d.rin     = NREGS'(1) << fld_d.ra;
        outs_d.zlowout = 1'b1;
        outs_d.busy    = 1'b1;
      end
      WB_HI: begin
        outs_d.rin      = NREGS'(1) << fld_d.rhi;
        outs_d.zhighout = 1'b1;
        outs_d.busy     = 1'b1;
      end
      DONE: begin
        outs_d.done = 1'b1;
        outs_d.busy = 1'b1;
      end
      default: outs_d = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      fld_q   <= '0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      outs_q  <= outs_d;
    end
  end

  assign Rout     = outs_q.rout;
  assign Rin      = outs_q.rin;
  assign Yin      = outs_q.yin;
  assign ZHighin  = outs_q.zhighin;
  assign Zlowin   = outs_q.zlowin;
  assign Zhighout = outs_q.zhighout;
  assign Zlowout  = outs_q.zlowout;
  assign op       = outs_q.op;
  assign busy     = outs_q.busy;
  assign done     = outs_q.done;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a step-list reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_alu_op_sequencer;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode = '0;
  logic        unary = 1'b0;
  logic [3:0]  ra = '0, rb = '0, rc = '0, rhi = '0;
  logic        wr_hi = 1'b0;
  logic [15:0] Rout, Rin;
  logic        Yin, ZHighin, Zlowin, Zhighout, Zlowout;
  logic [4:0]  op;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  alu_op_sequencer #(.NREGS(16), .OPW(5)) dut (
    .Clock(Clock), .clear(clear), .start(start), .opcode(opcode),
    .unary(unary), .ra(ra), .rb(rb), .rc(rc), .wr_hi(wr_hi), .rhi(rhi),
    .Rout(Rout), .Rin(Rin), .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .op(op), .busy(busy), .done(done)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs for one cycle of a sequence.
  typedef struct packed {
    logic [15:0] rout, rin;
    logic yin, zhin, zlin, zhout, zlout;
    logic [4:0] op;
    logic busy, done;
  } step_t;

  step_t q[$];
  step_t cur = '0;
  step_t s;

  // Model: an accepted request expands into its list of per-cycle steps;
  // after the list drains, one cycle returns to idle before a new accept.
  always @(posedge Clock or negedge clear) begin
    if (!clear) begin
      q.delete();
      cur = '0;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (cur.busy) begin
      cur = '0;
    end else if (start) begin
      if (!unary) begin
        s = '0; s.rout = 16'(1) << rb; s.yin = 1'b1; s.busy = 1'b1; q.push_back(s);
      end
      s = '0; s.rout = 16'(1) << rc; s.op = opcode; s.zhin = 1'b1; s.zlin = 1'b1;
      s.busy = 1'b1; q.push_back(s);
      s = '0; s.rin = 16'(1) << ra; s.zlout = 1'b1; s.busy = 1'b1; q.push_back(s);
      if (wr_hi) begin
        s = '0; s.rin = 16'(1) << rhi; s.zhout = 1'b1; s.busy = 1'b1; q.push_back(s);
      end
      s = '0; s.done = 1'b1; s.busy = 1'b1; q.push_back(s);
      cur = q.pop_front();
    end
  end

  always @(negedge Clock) begin
    check("Rout", Rout, cur.rout);
    check("Rin", Rin, cur.rin);
    check("Yin", Yin, cur.yin);
    check("ZHighin", ZHighin, cur.zhin);
    check("Zlowin", Zlowin, cur.zlin);
    check("Zhighout", Zhighout, cur.zhout);
    check("Zlowout", Zlowout, cur.zlout);
    check("op", op, cur.op);
    check("busy", busy, cur.busy);
    check("done", done, cur.done);
    check("Rout_onehot0", $onehot0(Rout), 1);
    check("Rin_onehot0", $onehot0(Rin), 1);
    check("Rout_Rin_excl", (|Rout) && (|Rin), 0);
  end

  task automatic drive(input logic st, input logic [4:0] opc, input logic un,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic wh, input logic [3:0] h);
    start = st; opcode = opc; unary = un; ra = a; rb = b; rc = c; wr_hi = wh; rhi = h;
  endtask

  initial begin
    int ndone;
    int idle_cnt;
    int bad_drive;
    #1 clear = 1'b0;
    repeat (2) @(negedge Clock);
    check("rst_Rout", Rout, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #1 clear = 1'b1;

    // Binary, wr_hi=0: SRA on R3/R2 into R1.
    @(negedge Clock); #1 drive(1, 5'b00101, 0, 4'd1, 4'd3, 4'd2, 0, 4'd0);
    @(negedge Clock);
    check("bin_c1_Rout", Rout, 16'h0008); check("bin_c1_Yin", Yin, 1);
    check("bin_c1_busy", busy, 1);
    #1 start = 1'b0; ra = 4'd9; rb = 4'd9; rc = 4'd9; opcode = 5'd3;
    @(negedge Clock);
    check("bin_c2_Rout", Rout, 16'h0004); check("bin_c2_op", op, 5'b00101);
    check("bin_c2_Zin", {ZHighin, Zlowin}, 2'b11);
    @(negedge Clock);
    check("bin_c3_Rin", Rin, 16'h0002); check("bin_c3_Zlowout", Zlowout, 1);
    check("bin_c3_op", op, 5'd0);
    @(negedge Clock);
    check("bin_c4_done", done, 1);
    @(negedge Clock);
    check("bin_c5_done", done, 0); check("bin_c5_busy", busy, 0);

    // Unary, wr_hi=1: rc=5, ra=6, rhi=0.
    #1 drive(1, 5'b01010, 1, 4'd6, 4'd7, 4'd5, 1, 4'd0);
    @(negedge Clock);
    check("un_c1_Rout", Rout, 16'h0020); check("un_c1_Yin", Yin, 0);
    #1 start = 1'b0;
    @(negedge Clock);
    check("un_c2_Rin", Rin, 16'h0040); check("un_c2_Zlowout", Zlowout, 1);
    check("un_c2_Yin", Yin, 0);
    @(negedge Clock);
    check("un_c3_Rin", Rin, 16'h0001); check("un_c3_Zhighout", Zhighout, 1);
    @(negedge Clock);
    check("un_c4_done", done, 1);
    @(negedge Clock);

    // Reset in the middle of EXEC.
    #1 drive(1, 5'b00101, 0, 4'd1, 4'd3, 4'd2, 0, 4'd0);
    @(negedge Clock); #1 start = 1'b0;
    @(negedge Clock);
    check("rx_op_pre", op, 5'b00101); check("rx_zh_pre", ZHighin, 1);
    #2 clear = 1'b0;
    #1;
    check("rx_op", op, 5'd0); check("rx_zh", ZHighin, 0); check("rx_busy", busy, 0);
    check("rx_Rout", Rout, 16'h0000);
    @(negedge Clock); #1 clear = 1'b1;
    ndone = 0;
    repeat (6) begin @(negedge Clock); if (done) ndone++; end
    check("rx_no_done", ndone, 0);

    // Second start during WB_LO with a different ra is ignored.
    #1 drive(1, 5'b00001, 0, 4'd1, 4'd3, 4'd2, 0, 4'd0);
    @(negedge Clock); #1 start = 1'b0;
    @(negedge Clock);
    @(negedge Clock); #1 drive(1, 5'b00001, 0, 4'd9, 4'd3, 4'd2, 0, 4'd0);
    ndone = 0; bad_drive = 0;
    @(negedge Clock); #1 start = 1'b0;
    if (done) ndone++;
    repeat (6) begin
      @(negedge Clock);
      if (done) ndone++;
      if (Rin == 16'h0200) bad_drive++;
    end
    check("rej_one_done", ndone, 1);
    check("rej_ra_never", bad_drive, 0);

    // Start held high for three back-to-back sequences.
    #1 drive(1, 5'b00110, 0, 4'd4, 4'd5, 4'd6, 0, 4'd0);
    ndone = 0; idle_cnt = 0;
    for (int i = 0; i < 40 && ndone < 3; i++) begin
      @(negedge Clock);
      if (done) begin
        if (ndone > 0) check("cont_gap", idle_cnt, 1);
        ndone++; idle_cnt = 0;
      end else if (!busy) idle_cnt++;
    end
    #1 start = 1'b0;
    check("cont_three_done", ndone, 3);
    repeat (3) @(negedge Clock);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      #1 drive(($urandom % 3) == 0, 5'($urandom), 1'($urandom), 4'($urandom),
               4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
      if (($urandom % 150) == 0) begin
        clear = 1'b0; #2 clear = 1'b1;
      end
      @(negedge Clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
